fft_frame_ctrl: RTL and testbench



---
 rtl/fft_frame_ctrl_pkg.sv | 23 ++
 rtl/fft_frame_ctrl_frame_buf.sv | 27 ++
 rtl/fft_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and constants for the FFT frame sequencer.
package fft_frame_ctrl_pkg;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned TO_W     = 16;
  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StPrefetch,
    StLoad,
    StStart,
    StWait,
    StFinish
  } ctrl_state_t;

  // Real sample in the upper half, zero imaginary part in the lower half.
  function automatic logic [2*SAMPLE_W-1:0] pack_real(input logic [SAMPLE_W-1:0] s);
    return {s, {SAMPLE_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fft_frame_ctrl_frame_buf.sv
// Frame buffer: simple dual-port RAM with one write port and a registered read port.
module frame_buf #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 512,
  parameter int unsigned AddrW = 9
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Captures a frame of left-channel samples, streams it into the FFT load port,
// starts the FFT and waits for done with a timeout.
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int unsigned bit_width = 16,
  parameter int unsigned M         = 9,
  parameter int unsigned N         = 512,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sample_valid,
  input  logic [bit_width-1:0]   sample,
  output logic                   fft_load,
  output logic [M-1:0]           fft_rd_adr,
  output logic [2*bit_width-1:0] fft_rd,
  output logic                   fft_start,
  input  logic                   fft_done,
  output logic                   busy,
  output logic                   frame_done,
  output logic [CNT_W-1:0]       frame_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   timeout_err
);

  localparam logic [M-1:0]    LAST     = M'(N - 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  ctrl_state_t           state_q, state_d;
  logic [M-1:0]          wr_ptr_q, wr_ptr_d;
  logic [M-1:0]          ld_cnt_q, ld_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic                  timeout_err_q, timeout_err_d;

  logic                  buf_we;
  logic                  buf_re;
  logic [M-1:0]          buf_raddr;
  logic [bit_width-1:0]  rd_data;
  logic [2*bit_width-1:0] packed_word;

  frame_buf #(
    .Width (bit_width),
    .Depth (N),
    .AddrW (M)
  ) u_frame_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (wr_ptr_q),
    .wr_data (sample),
    .rd_en   (buf_re),
    .rd_addr (buf_raddr),
    .rd_data (rd_data)
  );

  if (bit_width == SAMPLE_W) begin : g_pack_pkg
    assign packed_word = pack_real(rd_data);
  end else begin : g_pack_generic
    assign packed_word = {rd_data, {bit_width{1'b0}}};
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    ld_cnt_d      = ld_cnt_q;
    to_cnt_d      = to_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    timeout_err_d = timeout_err_q;
    buf_we        = 1'b0;
    buf_re        = 1'b0;
    buf_raddr     = '0;
    fft_load      = 1'b0;
    fft_start     = 1'b0;
    frame_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StCapture;
          wr_ptr_d = '0;
        end
      end
      StCapture: begin
        if (sample_valid) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
        // A strobe coinciding with enable falling is still written before aborting.
        if (!enable) begin
          state_d = StIdle;
        end else if (sample_valid && wr_ptr_q == LAST) begin
          state_d = StPrefetch;
        end
      end
      StPrefetch: begin
        buf_re   = 1'b1;
        buf_raddr = '0;
        ld_cnt_d = '0;
        state_d  = StLoad;
      end
      StLoad: begin
        fft_load  = 1'b1;
        buf_re    = 1'b1;
        buf_raddr = ld_cnt_q + 1'b1;
        ld_cnt_d  = ld_cnt_q + 1'b1;
        if (ld_cnt_q == LAST) begin
          state_d = StStart;
        end
      end
      StStart: begin
        fft_start = 1'b1;
        to_cnt_d  = '0;
        state_d   = StWait;
      end
      StWait: begin
        if (fft_done) begin
          state_d = StFinish;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_q == TO_LIMIT - 1'b1) begin
            timeout_err_d = 1'b1;
            state_d       = StIdle;
          end
        end
      end
      StFinish: begin
        frame_done  = 1'b1;
        frame_cnt_d = frame_cnt_q + 1'b1;
        if (enable) begin
          state_d  = StCapture;
          wr_ptr_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Idle with enable low is "off": strobes there are ignored, not dropped.
    if (sample_valid && state_q != StCapture && (state_q != StIdle || enable) &&
        drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      ld_cnt_q      <= '0;
      to_cnt_q      <= '0;
      frame_cnt_q   <= '0;
      drop_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      ld_cnt_q      <= ld_cnt_d;
      to_cnt_q      <= to_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign fft_rd_adr  = fft_load ? ld_cnt_q : '0;
  assign fft_rd      = fft_load ? packed_word : '0;
  assign busy        = (state_q != StIdle);
  assign frame_cnt   = frame_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with N = 8, M = 3, TIMEOUT = 20.
module tb_fft_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  logic [15:0] sample;
  logic        fft_load;
  logic [2:0]  fft_rd_adr;
  logic [31:0] fft_rd;
  logic        fft_start;
  logic        fft_done;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  fft_frame_ctrl #(
    .bit_width (16),
    .M         (3),
    .N         (8),
    .TIMEOUT   (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample       (sample),
    .fft_load     (fft_load),
    .fft_rd_adr   (fft_rd_adr),
    .fft_rd       (fft_rd),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Eight strobes base..base+7, three cycles apart; returns in the cycle after the last.
  task automatic capture_frame(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'b1;
      sample       = base + 16'(i);
      tick();
      sample_valid = 1'b0;
      if (i < 7) begin
        tick();
        tick();
      end
    end
  endtask

  // Checks the prefetch cycle and the eight load cycles; optional drop strobes and reset.
  task automatic load_frame(input logic [15:0] base, input int drop_a, input int drop_b,
                            input int rst_k);
    check("prefetch_no_load", fft_load, 1'b0);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("load_en", fft_load, 1'b1);
      check("load_adr", fft_rd_adr, k);
      check("load_data", fft_rd, {base + 16'(k), 16'h0000});
      if (k == rst_k) begin
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_load", fft_load, 1'b0);
        check("rst_start", fft_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_adr", fft_rd_adr, 3'd0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_drop_cnt", drop_cnt, 16'd0);
        check("rst_timeout", timeout_err, 1'b0);
        return;
      end
      sample_valid = (k == drop_a) || (k == drop_b);
      sample       = 16'hdead;
      tick();
    end
    sample_valid = 1'b0;
    check("load_len", fft_load, 1'b0);
    check("start_pulse", fft_start, 1'b1);
    check("start_busy", busy, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample       = '0;
    fft_done     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("init_load", fft_load, 1'b0);
    check("init_start", fft_start, 1'b0);
    check("init_busy", busy, 1'b0);
    check("init_frame_done", frame_done, 1'b0);
    check("init_rd", fft_rd, 32'd0);
    check("init_frame_cnt", frame_cnt, 16'd0);
    check("init_drop_cnt", drop_cnt, 16'd0);
    check("init_timeout", timeout_err, 1'b0);

    // Frame 1: samples 1..8, done five cycles after start.
    enable = 1'b1;
    tick();
    check("f1_busy", busy, 1'b1);
    capture_frame(16'h0001);
    load_frame(16'h0001, -1, -1, -1);
    for (int j = 1; j <= 5; j++) begin
      tick();
      check("f1_no_start", fft_start, 1'b0);
      check("f1_wait_no_done", frame_done, 1'b0);
    end
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("f1_frame_done", frame_done, 1'b1);
    tick();
    check("f1_done_once", frame_done, 1'b0);
    check("f1_frame_cnt", frame_cnt, 16'd1);
    check("f1_recapture_busy", busy, 1'b1);
    check("f1_drop_cnt", drop_cnt, 16'd0);

    // Frame 2: two drops during load, two during wait.
    capture_frame(16'h0011);
    load_frame(16'h0011, 2, 5, -1);
    tick();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    fft_done     = 1'b1;
    tick();
    fft_done = 1'b0;
    check("f2_frame_done", frame_done, 1'b1);
    tick();
    check("f2_frame_cnt", frame_cnt, 16'd2);
    check("f2_drop_cnt", drop_cnt, 16'd4);

    // Frame 3: fft_done never arrives.
    capture_frame(16'h0030);
    load_frame(16'h0030, -1, -1, -1);
    for (int j = 1; j <= 20; j++) begin
      tick();
      check("to_no_frame_done", frame_done, 1'b0);
      check("to_wait_busy", busy, 1'b1);
    end
    check("to_not_yet", timeout_err, 1'b0);
    tick();
    check("to_err", timeout_err, 1'b1);
    check("to_idle", busy, 1'b0);
    check("to_frame_cnt", frame_cnt, 16'd2);
    check("to_no_done", frame_done, 1'b0);
    tick();

    // Abort after three samples, then a fresh full frame.
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample       = 16'h00e0 + 16'(i);
      tick();
    end
    sample_valid = 1'b0;
    enable       = 1'b0;
    tick();
    check("abort_idle", busy, 1'b0);
    check("abort_no_load", fft_load, 1'b0);
    sample_valid = 1'b1;
    tick();
    check("idle_off_no_drop", drop_cnt, 16'd4);
    check("timeout_sticky", timeout_err, 1'b1);
    enable = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("idle_on_drop", drop_cnt, 16'd5);
    check("reenable_busy", busy, 1'b1);
    capture_frame(16'h0050);
    load_frame(16'h0050, -1, -1, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
